// File: rtl/ram_rd_check.sv
// Sequential read-back checker for a 64x8 RAM port B.
// Issues addresses 0..63 while rd_flag is high and compares each word against {2'b00, addr}.
module ram_rd_check #(
  // RAM port-B read latency in cycles; legal values are 1 and 2
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_flag,
  output logic        ram_rd_en,
  output logic [5:0]  ram_rd_addr,
  input  logic [7:0]  ram_rd_data,
  output logic [15:0] err_cnt,
  output logic        err_flag,
  output logic        lap_done,
  output logic [7:0]  lap_cnt
);

  localparam int unsigned LastStage = RD_LATENCY - 1;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRead = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic        ram_rd_en_q, ram_rd_en_d;
  logic [5:0]  ram_rd_addr_q, ram_rd_addr_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic        err_flag_q, err_flag_d;
  logic        lap_done_q, lap_done_d;
  logic [7:0]  lap_cnt_q, lap_cnt_d;

  // One (valid, addr) entry per cycle of RAM read latency
  logic [RD_LATENCY-1:0]      pipe_vld_q, pipe_vld_d;
  logic [RD_LATENCY-1:0][5:0] pipe_addr_q, pipe_addr_d;

  logic       abort;
  logic       cmp_vld;
  logic [5:0] cmp_addr;
  logic       mismatch;
  logic       lap_hit;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (rd_flag)  state_d = StRead;
      StRead: if (!rd_flag) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic: enable and address are registered from the next state
  always_comb begin
    ram_rd_en_d   = (state_d == StRead);
    ram_rd_addr_d = '0;
    if ((state_q == StRead) && (state_d == StRead)) begin
      ram_rd_addr_d = ram_rd_addr_q + 6'd1;
    end
  end

  assign abort = (state_q == StRead) && !rd_flag;

  // Read-tracking pipeline; leaving READ discards every read still in flight
  always_comb begin
    pipe_vld_d     = pipe_vld_q;
    pipe_addr_d    = pipe_addr_q;
    pipe_vld_d[0]  = ram_rd_en_q;
    pipe_addr_d[0] = ram_rd_addr_q;
    for (int i = 1; i < int'(RD_LATENCY); i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_addr_d[i] = pipe_addr_q[i-1];
    end
    if (abort) begin
      pipe_vld_d = '0;
    end
  end

  assign cmp_vld  = pipe_vld_q[LastStage];
  assign cmp_addr = pipe_addr_q[LastStage];
  assign mismatch = cmp_vld && (ram_rd_data != {2'b00, cmp_addr});
  assign lap_hit  = cmp_vld && (cmp_addr == 6'd63);

  // Saturating error and lap bookkeeping
  always_comb begin
    err_cnt_d  = err_cnt_q;
    err_flag_d = err_flag_q | mismatch;
    lap_done_d = lap_hit;
    lap_cnt_d  = lap_cnt_q;
    if (mismatch && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
    if (lap_hit && (lap_cnt_q != 8'hFF)) begin
      lap_cnt_d = lap_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_rd_en_q   <= 1'b0;
      ram_rd_addr_q <= '0;
      pipe_vld_q    <= '0;
      pipe_addr_q   <= '0;
      err_cnt_q     <= '0;
      err_flag_q    <= 1'b0;
      lap_done_q    <= 1'b0;
      lap_cnt_q     <= '0;
    end else begin
      ram_rd_en_q   <= ram_rd_en_d;
      ram_rd_addr_q <= ram_rd_addr_d;
      pipe_vld_q    <= pipe_vld_d;
      pipe_addr_q   <= pipe_addr_d;
      err_cnt_q     <= err_cnt_d;
      err_flag_q    <= err_flag_d;
      lap_done_q    <= lap_done_d;
      lap_cnt_q     <= lap_cnt_d;
    end
  end

  assign ram_rd_en   = ram_rd_en_q;
  assign ram_rd_addr = ram_rd_addr_q;
  assign err_cnt     = err_cnt_q;
  assign err_flag    = err_flag_q;
  assign lap_done    = lap_done_q;
  assign lap_cnt     = lap_cnt_q;

endmodule
